ysyx_24070014_mem_arbiter: RTL and testbench
============================================

Name: ysyx_24070014_mem_arbiter

Overview:
Shares a single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) for the multi-cycle core. It arbitrates round-robin on simultaneous requests and latches the winning request. It drives a valid/ready request to memory, routes the memory response back to the owner, and aborts with an error if memory does not respond within a timeout. Only one transaction is outstanding at a time.

Parameters:
ADDR_LEN, 32, address width
DATA_LEN, 32, data width
TIMEOUT, 255, max cycles from entering ISSUE to mem_resp_valid before abort; 0 disables the timeout

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_LEN  fetch address
ifu_resp_valid  out  1  one-cycle response pulse to IFU
ifu_resp_err  out  1  response was a timeout abort
ifu_rdata  out  DATA_LEN  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_LEN  load/store address
lsu_wen  in  1  1 = store
lsu_wdata  in  DATA_LEN  store data
lsu_wmask  in  DATA_LEN/8  byte strobes
lsu_resp_valid  out  1  one-cycle response pulse to LSU (load data or store ack)
lsu_resp_err  out  1  timeout abort
lsu_rdata  out  DATA_LEN  load data; 0 for stores
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_LEN  latched address
mem_wen  out  1  latched write enable
mem_wdata  out  DATA_LEN  latched write data
mem_wmask  out  DATA_LEN/8  latched strobes; forced 0 for IFU
mem_resp_valid  in  1  memory response/ack
mem_rdata  in  DATA_LEN  memory read data

Behaviour:
- States: IDLE, ISSUE, WAIT. Reset → IDLE, last_grant=IFU, timeout counter=0, all registered outputs 0.
- Request acceptance (IDLE only):
  - The ready signals are combinational: nonzero only in IDLE, and at most one is high.
  - IFU only valid → ifu_req_ready=1. LSU only valid → lsu_req_ready=1.
  - Both valid → grant the requester ≠ last_grant. After reset, the first tie therefore goes to LSU.
  - Accept edge: latch addr/wen/wdata/wmask and the owner, set last_grant=owner, go to ISSUE, clear the counter.
  - IFU requests latch wen=0 and wmask=0.
- ISSUE:
  - mem_req_valid=1 with stable latched fields.
  - mem_req_ready=1 → WAIT at the next edge. mem_req_valid is not asserted in WAIT.
- WAIT:
  - On mem_resp_valid, register mem_rdata (0 if a store) into owner_rdata.
  - Next cycle: owner_resp_valid=1 for exactly one cycle, resp_err=0. State returns to IDLE on the same edge.
- Timeout (TIMEOUT≠0):
  - The counter increments every cycle in ISSUE/WAIT.
  - On reaching TIMEOUT without mem_resp_valid: next cycle owner_resp_valid=1, resp_err=1, rdata=0; state → IDLE.
  - If mem_resp_valid arrives in the same cycle the counter reaches TIMEOUT, the response wins (err=0).
- Latency:
  - Minimum accept-to-response is 3 cycles: accept edge → ISSUE (ready=1) → WAIT (resp_valid=1) → resp pulse.
  - A new request may be accepted in the same cycle the response pulse is driven.
- mem_resp_valid in IDLE or ISSUE is ignored. Memory must not respond to an aborted transaction after the timeout; that is a system constraint, not checked here.
- Non-owner resp_valid is always 0. rdata/err outputs hold their value between pulses.
- Reset mid-transaction: immediate IDLE, no response pulse, the pending transaction is dropped, last_grant returns to IFU.

Decomposition:
- Shared definitions header: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2) and owner encoding (OWNER_IFU=1'b0, OWNER_LSU=1'b1), following the ysyx_24070014_ macro style.
- One sub-module, ysyx_24070014_rr_arbiter2: a combinational 2-way grant computed from (req0, req1, last_grant), outputs grant0/grant1. The FSM, latches, and counter stay in the top block.

Test Plan:
- IFU-only read addr 0x80000000, mem ready at once, resp 0x00000413 one cycle later → ifu_resp_valid in cycle 3, ifu_rdata=0x00000413, err=0, lsu_resp_valid=0.
- IFU and LSU valid together after reset → LSU granted first. The next simultaneous tie goes to IFU, the third to LSU.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011; mem_req_ready low for 4 cycles → mem_* fields stable all 4 cycles; on ack, lsu_resp_valid=1 and lsu_rdata=0.
- TIMEOUT=8, memory never responds → lsu_resp_valid with lsu_resp_err=1 and rdata=0 exactly 8 cycles after entering ISSUE (+1 pulse cycle); the FSM then accepts a new request.
- Response coinciding with timeout expiry (mem_resp_valid=1 when the counter reaches TIMEOUT) → err=0 and data delivered.
- Reset asserted in WAIT, mem_resp_valid arriving one cycle after reset deasserts → no resp pulse, FSM in IDLE, last_grant=IFU.

Source files
------------

// File: rtl/ysyx_24070014_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM state and owner encodings.
package ysyx_24070014_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24070014_rr_arbiter2.sv
// Two-way round-robin grant: a lone request always wins; on a tie the
// requester that did not win last time is granted.
module ysyx_24070014_rr_arbiter2
  import ysyx_24070014_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  // Grant decode: at most one grant high, ties alternate against last_grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0 && req1) begin
      if (last_grant == OWNER_IFU) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = req0;
      grant1 = req1;
    end
  end

endmodule

// File: rtl/ysyx_24070014_mem_arbiter.sv
// Memory port arbiter for the multi-cycle core. One transaction is in flight
// at a time: IDLE accepts a request, ISSUE holds a valid/ready request to
// memory, WAIT collects the response. A watchdog aborts with an error pulse
// when memory stays silent for TIMEOUT cycles.
module ysyx_24070014_mem_arbiter
  import ysyx_24070014_mem_arbiter_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_LEN-1:0]     ifu_addr,
  output logic                    ifu_resp_valid,
  output logic                    ifu_resp_err,
  output logic [DATA_LEN-1:0]     ifu_rdata,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_LEN-1:0]     lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_LEN-1:0]     lsu_wdata,
  input  logic [DATA_LEN/8-1:0]   lsu_wmask,
  output logic                    lsu_resp_valid,
  output logic                    lsu_resp_err,
  output logic [DATA_LEN-1:0]     lsu_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_LEN-1:0]     mem_addr,
  output logic                    mem_wen,
  output logic [DATA_LEN-1:0]     mem_wdata,
  output logic [DATA_LEN/8-1:0]   mem_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_LEN-1:0]     mem_rdata
);

  localparam int                 CNT_W      = $clog2(TIMEOUT + 2);
  // Counter value during the last permitted cycle; it reaches TIMEOUT at that edge.
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic               TIMEOUT_EN = (TIMEOUT != 0);

  arb_state_e            state_r;
  arb_state_e            state_nx_s;
  logic                  owner_r;
  logic                  last_grant_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  grant_ifu_s;
  logic                  grant_lsu_s;
  logic                  accept_s;
  logic                  resp_ok_s;
  logic                  abort_s;
  logic                  timeout_hit_s;
  logic                  finish_s;
  logic [DATA_LEN-1:0]   resp_data_s;

  ysyx_24070014_rr_arbiter2 u_rr (
    .req0       (ifu_req_valid),
    .req1       (lsu_req_valid),
    .last_grant (last_grant_r),
    .grant0     (grant_ifu_s),
    .grant1     (grant_lsu_s)
  );

  assign ifu_req_ready = (state_r == IDLE) && grant_ifu_s;
  assign lsu_req_ready = (state_r == IDLE) && grant_lsu_s;
  assign mem_req_valid = (state_r == ISSUE);
  assign timeout_hit_s = TIMEOUT_EN && (cnt_r == CNT_LAST);
  assign finish_s      = resp_ok_s || abort_s;

  // Next-state logic; a response in the final watchdog cycle beats the abort.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    resp_ok_s  = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_ifu_s || grant_lsu_s) begin
          accept_s   = 1'b1;
          state_nx_s = ISSUE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        if (timeout_hit_s) begin
          abort_s    = 1'b1;
          state_nx_s = IDLE;
        end else if (mem_req_ready) begin
          state_nx_s = WAIT;
        end else begin
          state_nx_s = ISSUE;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          resp_ok_s  = 1'b1;
          state_nx_s = IDLE;
        end else if (timeout_hit_s) begin
          abort_s    = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Data returned to the owner: loads pass memory data, stores and aborts return zero.
  always_comb begin
    resp_data_s = '0;
    if (resp_ok_s && !mem_wen) begin
      resp_data_s = mem_rdata;
    end else begin
      resp_data_s = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Latch the winning request; IFU fetches never write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r      <= OWNER_IFU;
      last_grant_r <= OWNER_IFU;
      mem_addr     <= '0;
      mem_wen      <= 1'b0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
    end else if (accept_s) begin
      owner_r      <= grant_lsu_s ? OWNER_LSU : OWNER_IFU;
      last_grant_r <= grant_lsu_s ? OWNER_LSU : OWNER_IFU;
      mem_addr     <= grant_lsu_s ? lsu_addr : ifu_addr;
      mem_wen      <= grant_lsu_s && lsu_wen;
      mem_wdata    <= grant_lsu_s ? lsu_wdata : '0;
      mem_wmask    <= grant_lsu_s ? lsu_wmask : '0;
    end else begin
      owner_r      <= owner_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Watchdog counter: cleared on accept, counts every ISSUE/WAIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= '0;
    end else if ((state_r == ISSUE) || (state_r == WAIT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Response pulse to the owner; data and error hold between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifu_resp_valid <= 1'b0;
      ifu_resp_err   <= 1'b0;
      ifu_rdata      <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_err   <= 1'b0;
      lsu_rdata      <= '0;
    end else begin
      ifu_resp_valid <= finish_s && (owner_r == OWNER_IFU);
      lsu_resp_valid <= finish_s && (owner_r == OWNER_LSU);
      if (finish_s && (owner_r == OWNER_IFU)) begin
        ifu_resp_err <= abort_s;
        ifu_rdata    <= resp_data_s;
      end else begin
        ifu_resp_err <= ifu_resp_err;
        ifu_rdata    <= ifu_rdata;
      end
      if (finish_s && (owner_r == OWNER_LSU)) begin
        lsu_resp_err <= abort_s;
        lsu_rdata    <= resp_data_s;
      end else begin
        lsu_resp_err <= lsu_resp_err;
        lsu_rdata    <= lsu_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24070014_mem_arbiter.sv
// Self-checking bench for ysyx_24070014_mem_arbiter (TIMEOUT = 8).
module tb_ysyx_24070014_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  ysyx_24070014_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic [31:0] ifu_a;
    logic [31:0] lsu_a;
    logic        lsu_we;
    logic [31:0] lsu_wd;
    logic [3:0]  lsu_wm;
    logic [31:0] mem_rd;
    logic        exp_lsu;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start of a cycle: just after the rising edge, where inputs are driven.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sample point.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 1'b0; ifu_addr = 32'd0;
    lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0;
    lsu_wdata = 32'd0; lsu_wmask = 4'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
  endtask

  // Minimum-latency transaction: accept, ready at once, response next cycle.
  task automatic run_vec(input vec_t v, input int idx);
    nxt();
    ifu_req_valid = v.ifu_v; ifu_addr = v.ifu_a;
    lsu_req_valid = v.lsu_v; lsu_addr = v.lsu_a; lsu_wen = v.lsu_we;
    lsu_wdata = v.lsu_wd; lsu_wmask = v.lsu_wm;
    smp();
    chk($sformatf("vec%0d ifu_req_ready", idx), ifu_req_ready, !v.exp_lsu);
    chk($sformatf("vec%0d lsu_req_ready", idx), lsu_req_ready, v.exp_lsu);
    nxt();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk($sformatf("vec%0d mem_req_valid", idx), mem_req_valid, 1'b1);
    chk($sformatf("vec%0d mem_addr", idx), mem_addr, v.exp_addr);
    chk($sformatf("vec%0d mem_wen", idx), mem_wen, v.exp_lsu && v.lsu_we);
    nxt();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = v.mem_rd;
    smp();
    chk($sformatf("vec%0d mem_req_valid wait", idx), mem_req_valid, 1'b0);
    nxt();
    mem_resp_valid = 1'b0; mem_rdata = 32'd0;
    smp();
    chk($sformatf("vec%0d ifu_resp_valid", idx), ifu_resp_valid, !v.exp_lsu);
    chk($sformatf("vec%0d lsu_resp_valid", idx), lsu_resp_valid, v.exp_lsu);
    if (v.exp_lsu) begin
      chk($sformatf("vec%0d lsu_rdata", idx), lsu_rdata, v.exp_rdata);
      chk($sformatf("vec%0d lsu_resp_err", idx), lsu_resp_err, 1'b0);
    end else begin
      chk($sformatf("vec%0d ifu_rdata", idx), ifu_rdata, v.exp_rdata);
      chk($sformatf("vec%0d ifu_resp_err", idx), ifu_resp_err, 1'b0);
    end
  endtask

  initial begin
    logic        m_last;
    int          p, d_r, d_v, r, pulse;
    logic        w_lsu, resp_on, st;
    logic [31:0] ia, la, wd, rd, exp_rd;
    logic [3:0]  wm;

    //            ifu_v lsu_v ifu_a         lsu_a         we    wd            wm     mem_rd        lsu   addr          rdata
    vecs[0] = '{1'b1, 1'b0, 32'h80000000, 32'h0,        1'b0, 32'h0,        4'h0,  32'h00000413, 1'b0, 32'h80000000, 32'h00000413};
    vecs[1] = '{1'b1, 1'b1, 32'h80000004, 32'h80000100, 1'b0, 32'h0,        4'hF,  32'h11112222, 1'b1, 32'h80000100, 32'h11112222};
    vecs[2] = '{1'b1, 1'b1, 32'h80000008, 32'h80000104, 1'b0, 32'h0,        4'hF,  32'h33334444, 1'b0, 32'h80000008, 32'h33334444};
    vecs[3] = '{1'b1, 1'b1, 32'h8000000C, 32'h80000108, 1'b1, 32'hA5A5A5A5, 4'hF,  32'h55556666, 1'b1, 32'h80000108, 32'h00000000};
    vecs[4] = '{1'b0, 1'b1, 32'h0,        32'h8000010C, 1'b0, 32'h0,        4'h3,  32'h77778888, 1'b1, 32'h8000010C, 32'h77778888};
    vecs[5] = '{1'b1, 1'b1, 32'h80000010, 32'h80000110, 1'b0, 32'h0,        4'hF,  32'h9999AAAA, 1'b0, 32'h80000010, 32'h9999AAAA};

    clear_inputs();
    reset = 1'b1;
    smp();
    chk("reset mem_req_valid", mem_req_valid, 1'b0);
    chk("reset ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk("reset lsu_resp_valid", lsu_resp_valid, 1'b0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wmask", mem_wmask, 4'd0);
    chk("reset ifu_rdata", ifu_rdata, 32'd0);
    chk("reset lsu_rdata", lsu_rdata, 32'd0);
    nxt();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    // Store held off by memory for 4 cycles; latched fields must not move.
    nxt();
    lsu_req_valid = 1'b1; lsu_addr = 32'h80001000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'b0011;
    smp();
    chk("st lsu_req_ready", lsu_req_ready, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      nxt();
      lsu_req_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'hC;
      mem_req_ready = 1'b0;
      smp();
      chk("st mem_req_valid", mem_req_valid, 1'b1);
      chk("st mem_addr", mem_addr, 32'h80001000);
      chk("st mem_wen", mem_wen, 1'b1);
      chk("st mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("st mem_wmask", mem_wmask, 4'b0011);
    end
    nxt();
    mem_req_ready = 1'b1;
    smp();
    chk("st mem_req_valid ready", mem_req_valid, 1'b1);
    nxt();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h12345678;
    smp();
    chk("st mem_req_valid wait", mem_req_valid, 1'b0);
    chk("st early lsu_resp_valid", lsu_resp_valid, 1'b0);
    nxt();
    mem_resp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h80000020;
    smp();
    chk("st lsu_resp_valid", lsu_resp_valid, 1'b1);
    chk("st lsu_rdata", lsu_rdata, 32'd0);
    chk("st lsu_resp_err", lsu_resp_err, 1'b0);
    chk("st ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk("b2b ifu_req_ready", ifu_req_ready, 1'b1);
    nxt();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("b2b mem_addr", mem_addr, 32'h80000020);
    chk("b2b mem_wen", mem_wen, 1'b0);
    chk("b2b mem_wmask", mem_wmask, 4'd0);
    chk("b2b lsu pulse one cycle", lsu_resp_valid, 1'b0);
    nxt();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
    nxt();
    mem_resp_valid = 1'b0;
    smp();
    chk("b2b ifu_resp_valid", ifu_resp_valid, 1'b1);
    chk("b2b ifu_rdata", ifu_rdata, 32'hCAFEF00D);
    chk("b2b lsu_rdata hold", lsu_rdata, 32'd0);

    // Response arrives in the very cycle the watchdog would fire: data wins.
    nxt();
    lsu_req_valid = 1'b1; lsu_addr = 32'h80002000; lsu_wen = 1'b0;
    for (int c = 1; c <= TO + 1; c++) begin
      nxt();
      lsu_req_valid = 1'b0;
      mem_req_ready = (c == 1);
      mem_resp_valid = (c == TO);
      mem_rdata = (c == TO) ? 32'h0BADF00D : 32'd0;
      smp();
      chk("race lsu_resp_valid", lsu_resp_valid, c == TO + 1);
    end
    mem_resp_valid = 1'b0;
    chk("race lsu_resp_err", lsu_resp_err, 1'b0);
    chk("race lsu_rdata", lsu_rdata, 32'h0BADF00D);

    // Memory never answers: abort pulse TO cycles after entering ISSUE.
    nxt();
    lsu_req_valid = 1'b1; lsu_addr = 32'h80003000;
    for (int c = 1; c <= TO; c++) begin
      nxt();
      lsu_req_valid = 1'b0;
      mem_req_ready = (c == 1);
      smp();
      chk("to lsu_resp_valid quiet", lsu_resp_valid, 1'b0);
    end
    nxt();
    mem_req_ready = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h80000040;
    smp();
    chk("to lsu_resp_valid", lsu_resp_valid, 1'b1);
    chk("to lsu_resp_err", lsu_resp_err, 1'b1);
    chk("to lsu_rdata", lsu_rdata, 32'd0);
    chk("to new ifu_req_ready", ifu_req_ready, 1'b1);
    nxt();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("to new mem_addr", mem_addr, 32'h80000040);
    nxt();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h00100073;
    nxt();
    mem_resp_valid = 1'b0;
    smp();
    chk("to new ifu_rdata", ifu_rdata, 32'h00100073);
    chk("to lsu_resp_err hold", lsu_resp_err, 1'b1);

    // Reset while an LSU load sits in WAIT: dropped, grant history back to IFU.
    nxt();
    lsu_req_valid = 1'b1; lsu_addr = 32'h80004000;
    nxt();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    nxt();
    mem_req_ready = 1'b0;
    nxt();
    reset = 1'b1;
    smp();
    chk("rst mem_req_valid", mem_req_valid, 1'b0);
    chk("rst lsu_resp_valid", lsu_resp_valid, 1'b0);
    nxt();
    reset = 1'b0;
    nxt();
    mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF0000;
    smp();
    chk("rst mem_req_valid idle", mem_req_valid, 1'b0);
    nxt();
    mem_resp_valid = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    smp();
    chk("rst no lsu pulse", lsu_resp_valid, 1'b0);
    chk("rst no ifu pulse", ifu_resp_valid, 1'b0);
    chk("rst tie lsu_req_ready", lsu_req_ready, 1'b1);
    chk("rst tie ifu_req_ready", ifu_req_ready, 1'b0);

    // Randomized transactions against a transaction-level timing model.
    nxt();
    clear_inputs();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    m_last = 1'b0;
    for (int t = 0; t < 60; t++) begin
      p   = $urandom_range(0, 2);
      ia  = $urandom; la = $urandom; wd = $urandom; rd = $urandom;
      wm  = 4'($urandom);
      st  = 1'($urandom_range(0, 1));
      d_r = $urandom_range(0, 5);
      d_v = $urandom_range(0, 6);
      w_lsu   = (p == 1) || ((p == 2) && (m_last == 1'b0));
      r       = d_r + 2 + d_v;
      resp_on = (r <= TO) && ($urandom_range(0, 3) != 0);
      pulse   = resp_on ? r + 1 : TO + 1;
      exp_rd  = (resp_on && !(w_lsu && st)) ? rd : 32'd0;

      nxt();
      ifu_req_valid = (p != 1); ifu_addr = ia;
      lsu_req_valid = (p != 0); lsu_addr = la; lsu_wen = st;
      lsu_wdata = wd; lsu_wmask = wm;
      smp();
      chk("rnd ifu_req_ready", ifu_req_ready, !w_lsu);
      chk("rnd lsu_req_ready", lsu_req_ready, w_lsu);
      m_last = w_lsu;
      for (int c = 1; c <= TO + 2; c++) begin
        nxt();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
        mem_req_ready = (c == d_r + 1);
        if (c <= d_r + 1) begin
          mem_resp_valid = 1'($urandom_range(0, 1));
        end else begin
          mem_resp_valid = resp_on && (c == r);
        end
        mem_rdata = (c == r) ? rd : $urandom;
        smp();
        chk("rnd mem_req_valid", mem_req_valid, c <= d_r + 1);
        if (c <= d_r + 1) begin
          chk("rnd mem_addr", mem_addr, w_lsu ? la : ia);
          chk("rnd mem_wen", mem_wen, w_lsu && st);
          chk("rnd mem_wmask", mem_wmask, w_lsu ? wm : 4'd0);
          if (w_lsu && st) begin
            chk("rnd mem_wdata", mem_wdata, wd);
          end
        end
        chk("rnd ifu_resp_valid", ifu_resp_valid, !w_lsu && (c == pulse));
        chk("rnd lsu_resp_valid", lsu_resp_valid, w_lsu && (c == pulse));
        if (c == pulse) begin
          chk("rnd rdata", w_lsu ? lsu_rdata : ifu_rdata, exp_rd);
          chk("rnd resp_err", w_lsu ? lsu_resp_err : ifu_resp_err, !resp_on);
        end
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
